// File: rtl/div32u16_seq.sv
// Sequential radix-2 restoring divider, 32/16 -> 16-bit quotient and remainder, one op in flight.
// Latency: N = 16-APPROX_BITS cycles after acceptance (errors: result right after acceptance).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module div32u16_seq #(
    parameter int APPROX_BITS = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [15:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] Q,
    output logic [15:0] R,
    output logic        err_div0,
    output logic        err_ovf
);

    localparam int N = 16 - APPROX_BITS;
    localparam logic [4:0] LAST = 5'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] dq_q, dq_d;
    logic [15:0] b_q, b_d;
    logic [15:0] q_q, q_d;
    logic [15:0] r_q, r_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        out_valid_q, out_valid_d;
    logic        err_div0_q, err_div0_d;
    logic        err_ovf_q, err_ovf_d;

    logic [16:0] trial;
    logic [15:0] diff;
    logic        ge;
    logic [15:0] rem_step;
    logic [15:0] dq_step;

    always_comb begin
        // rem < b always holds, so a successful subtract fits in 16 bits
        trial    = {rem_q, dq_q[15]};
        diff     = trial[15:0] - b_q;
        ge       = (trial >= {1'b0, b_q});
        rem_step = ge ? diff : trial[15:0];
        dq_step  = {dq_q[14:0], ge};

        state_d     = state_q;
        rem_d       = rem_q;
        dq_d        = dq_q;
        b_d         = b_q;
        q_d         = q_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        err_div0_d  = err_div0_q;
        err_ovf_d   = err_ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (B == 16'd0) begin
                        state_d     = DONE;
                        q_d         = 16'hFFFF;
                        r_d         = 16'd0;
                        err_div0_d  = 1'b1;
                        err_ovf_d   = 1'b0;
                        out_valid_d = 1'b1;
                    end else if (A[31:16] >= B) begin
                        state_d     = DONE;
                        q_d         = 16'hFFFF;
                        r_d         = 16'd0;
                        err_div0_d  = 1'b0;
                        err_ovf_d   = 1'b1;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d    = CALC;
                        rem_d      = A[31:16];
                        dq_d       = A[15:0];
                        b_d        = B;
                        err_div0_d = 1'b0;
                        err_ovf_d  = 1'b0;
                        cnt_d      = 5'd0;
                    end
                end
            end
            CALC: begin
                rem_d = rem_step;
                dq_d  = dq_step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    if (APPROX_BITS == 0) begin
                        q_d = dq_step;
                        r_d = rem_step;
                    end else begin
                        // skipped iterations leave the low quotient bits as zero
                        q_d = dq_step << APPROX_BITS;
                        r_d = 16'd0;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= 16'd0;
            dq_q        <= 16'd0;
            b_q         <= 16'd0;
            q_q         <= 16'd0;
            r_q         <= 16'd0;
            cnt_q       <= 5'd0;
            out_valid_q <= 1'b0;
            err_div0_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            dq_q        <= dq_d;
            b_q         <= b_d;
            q_q         <= q_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            err_div0_q  <= err_div0_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign Q         = q_q;
    assign R         = r_q;
    assign err_div0  = err_div0_q;
    assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_div32u16_seq.sv
// Directed bench for div32u16_seq: exact instance plus an APPROX_BITS=4 instance,
// expected results queued at stimulus time and popped when a result appears.
module tb_div32u16_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_valid_a = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] A = 32'd0;
    logic [15:0] B = 16'd0;

    logic        in_ready, out_valid, err_div0, err_ovf;
    logic [15:0] Q, R;
    logic        in_ready_a, out_valid_a, err_div0_a, err_ovf_a;
    logic [15:0] Q_a, R_a;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        d0;
        logic        ov;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    div32u16_seq #(.APPROX_BITS(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .Q(Q), .R(R), .err_div0(err_div0), .err_ovf(err_ovf)
    );

    div32u16_seq #(.APPROX_BITS(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .A(A), .B(B), .out_valid(out_valid_a), .out_ready(out_ready),
        .Q(Q_a), .R(R_a), .err_div0(err_div0_a), .err_ovf(err_ovf_a)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [15:0] b);
        exp_t e;
        if (b == 16'd0)            e = '{q: 16'hFFFF, r: 16'd0, d0: 1'b1, ov: 1'b0};
        else if (a[31:16] >= b)    e = '{q: 16'hFFFF, r: 16'd0, d0: 1'b0, ov: 1'b1};
        else                       e = '{q: 16'(a / b), r: 16'(a % b), d0: 1'b0, ov: 1'b0};
        return e;
    endfunction

    task automatic start(input logic [31:0] a, input logic [15:0] b);
        @(negedge clk);
        A = a;
        B = b;
        in_valid = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int exp_lat);
        int cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    endtask

    task automatic compare_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_Q"}, 32'(Q), 32'(e.q));
            chk({tag, "_R"}, 32'(R), 32'(e.r));
            chk({tag, "_div0"}, 32'(err_div0), 32'(e.d0));
            chk({tag, "_ovf"}, 32'(err_ovf), 32'(e.ov));
        end
    endtask

    task automatic handshake(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_irdy_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int   cyc;
        logic [15:0] held_q;
        logic [15:0] exp_aq;

        // reset state
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_QR", {Q, R}, 32'd0);
        chk("rst_flags", {30'd0, err_div0, err_ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic exact division
        start(32'd100, 16'd7);
        chk("t1_busy", 32'(in_ready), 32'd0);
        wait_out("t1", 16);
        compare_result("t1");
        handshake("t1");

        // maximal non-overflowing dividend
        start(32'hFFFE_FFFF, 16'hFFFF);
        wait_out("t2", 16);
        compare_result("t2");
        handshake("t2");

        // overflow, div0, and div0 priority over overflow
        start(32'h0001_0000, 16'd1);
        wait_out("ovf", 0);
        compare_result("ovf");
        handshake("ovf");
        start(32'd5, 16'd0);
        wait_out("div0", 0);
        compare_result("div0");
        handshake("div0");
        start(32'hFFFF_0000, 16'd0);
        wait_out("div0p", 0);
        compare_result("div0p");
        handshake("div0p");

        // output stall with an ignored request in the middle
        out_ready = 1'b0;
        start(32'd1000, 16'd3);
        wait_out("stall", 16);
        held_q = Q;
        @(negedge clk);
        A = 32'd7;
        B = 16'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_ov", 32'(out_valid), 32'd1);
            chk("stall_irdy", 32'(in_ready), 32'd0);
            chk("stall_Q", 32'(Q), 32'(held_q));
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        compare_result("stall");
        handshake("stall");
        @(posedge clk);
        #1;
        chk("stall_noacc", 32'(out_valid), 32'd0);

        // reset mid-calculation aborts the operation
        start(32'd1000, 16'd3);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ov", 32'(out_valid), 32'd0);
        chk("abort_QR", {Q, R}, 32'd0);
        chk("abort_irdy", 32'(in_ready), 32'd1);
        void'(sb.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        start(32'd1000, 16'd3);
        wait_out("after_rst", 16);
        compare_result("after_rst");
        handshake("after_rst");

        // approximate instance skips four quotient iterations
        @(negedge clk);
        A = 32'd1000;
        B = 16'd3;
        exp_aq = 16'(((32'd1000 >> 4) / 32'd3) << 4);
        in_valid_a = 1'b1;
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        cyc = 0;
        while (!out_valid_a && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("approx_latency", 32'(cyc), 32'd12);
        chk("approx_Q", 32'(Q_a), 32'(exp_aq));
        chk("approx_R", 32'(R_a), 32'd0);
        chk("approx_flags", {30'd0, err_div0_a, err_ovf_a}, 32'd0);
        @(posedge clk);
        #1;
        chk("approx_drop", 32'(out_valid_a), 32'd0);
        chk("approx_irdy", 32'(in_ready_a), 32'd1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
